operand_hazard_unit: RTL
========================

// Module: operand_hazard_unit
// PURPOSE
//  Parametrised forwarding + hazard unit for the RV32I pipeline: per-source forwarding select across NUM_STAGES
//  producer stages (youngest wins), load-use/long-latency stall generation, and a 32-entry busy scoreboard that
//  tracks multi-cycle producers (loads on cache miss, future M-ext ops) until writeback. Sits beside ID/EX; drives
//  every operand forwarding mux and the global stall.
// PARAMETERS
//  NUM_SRC     2  number of source operands checked (rs1, rs2, ...)
//  NUM_STAGES  2  producer stages after EX, index 0 = youngest (EX/MEM), NUM_STAGES-1 = oldest (MEM/WB)
//  SEL_W       $clog2(NUM_STAGES+1)  width of one forwarding select
// PORTS
//  clk              in   1                 clock
//  rst              in   1                 reset
//  flush            in   1                 pipeline flush (branch mispredict)
//  src_rs           in   NUM_SRC*5         source register indices, slice i = source i
//  src_used         in   NUM_SRC           source i is actually read by the instruction
//  stage_rd         in   NUM_STAGES*5      destination register of each producer stage
//  stage_load_rf    in   NUM_STAGES        stage will write the regfile
//  stage_ready      in   NUM_STAGES        stage's result is available for forwarding this cycle
//  issue_valid      in   1                 instruction advancing out of ID this cycle
//  issue_rd         in   5                 its destination
//  issue_long       in   1                 it is a long-latency producer (scoreboarded)
//  wb_valid         in   1                 regfile write this cycle
//  wb_rd            in   5                 regfile write index
//  fwd_sel          out  NUM_SRC*SEL_W     0 = regfile, k = forward from stage k-1
//  stall            out  1                 hold IF/ID, bubble into EX
//  busy_vec         out  32                scoreboard state (debug)
//  stall_cycles     out  32                only with HAZARD_PERF_EN
// BEHAVIOUR
//  - Synchronous active-high reset; one clock domain, all state updates on posedge clk.
//  - Reset: busy_vec = 0, stall_cycles = 0. fwd_sel and stall are combinational; with zero stage_load_rf they are 0.
//  - Forwarding (combinational): for source i, match k = lowest index with stage_load_rf[k] && stage_rd[k]!=0 &&
//    stage_rd[k]==src_rs[i]; fwd_sel[i] = k+1, else 0. x0 never forwards, never stalls.
//  - Stall (combinational) = OR over used sources i of:
//      (a) a match exists and stage_ready[k]==0 (load-use, older matches ignored);
//      (b) no match and busy_vec[src_rs[i]]==1 (long op still outstanding, not yet in a ready stage).
//  - Unused sources (src_used[i]==0) still report fwd_sel but never raise stall.
//  - Scoreboard, per register r, next state:
//      set   when issue_valid && !stall && issue_long && issue_rd==r && r!=0
//      clear when wb_valid && wb_rd==r
//      set and clear same r same cycle -> set wins (issue is younger than writeback).
//      flush -> all bits clear, except a same-cycle set is suppressed too (flushed issue).
//      rst overrides flush and set.
//  - issue_valid while stall=1 is ignored by the scoreboard (instruction did not advance).
//  - busy_vec[0] is constant 0.
//  - Latency: scoreboard set visible to stall one cycle after issue; wb clear visible the next cycle (regfile
//    write-through covers the gap; no extra stall cycle).
// CONFIGURATION
//  HAZARD_PERF_EN defined: stall_cycles increments every cycle stall==1, saturates at 32'hFFFF_FFFF, cleared by rst.
//  Not defined: port stall_cycles omitted, no counter logic.
// STRUCTURE
//  - rv32i_types gains package hazard: localparam FWD_SEL_REGFILE = 0; function fwd_sel_of_stage(k) = k+1.
//  - Sub-module reg_scoreboard (32 busy bits, set/clear/flush ports, priority rules above); top holds
//    the generate loops for match priority, stall OR-reduction and optional perf counter.
// TESTING
//  - rs1=5, stage0 rd=5 ready, stage1 rd=5 -> fwd_sel[0]=1 (youngest), stall=0.
//  - rs2=7, stage0 rd=7 load_rf=1 ready=0 -> stall=1; next cycle ready=1 -> stall=0, fwd_sel[1]=1.
//  - Issue long rd=9; next cycle rs1=9, no stage match -> stall=1; wb_rd=9 -> busy[9]=0 next cycle, stall drops.
//  - Same cycle issue long rd=3 and wb rd=3 -> busy[3]=1 after edge; flush same cycle instead -> busy[3]=0.
//  - rs1=0 with stage0 rd=0 load_rf=1 -> fwd_sel=0, stall=0; issue long rd=0 -> busy_vec stays 0.
//  - HAZARD_PERF_EN: 4 stall cycles then rst -> counter reads 4, then 0; rst during busy clears busy_vec.

Source files
------------

// File: rtl/operand_hazard_unit_pkg.sv
// Shared definitions for the operand hazard unit.
// FWD_SEL_REGFILE : forwarding select value meaning "read the regfile"
// fwd_sel_of_stage: maps producer stage index k to its forwarding select code
package operand_hazard_unit_pkg;

  localparam int unsigned FWD_SEL_REGFILE = 0;
  localparam int unsigned NUM_REGS        = 32;
  localparam int unsigned REG_IDX_W       = 5;

  function automatic int unsigned fwd_sel_of_stage(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/operand_hazard_unit_reg_scoreboard.sv
// Busy-bit scoreboard for multi-cycle producers (one bit per architectural register).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           clear every busy bit; a same-cycle set is dropped too
//   set_en, set_rd  mark set_rd busy (set wins over a same-cycle clear)
//   clr_en, clr_rd  writeback of clr_rd retires its busy bit
//   busy            current busy bits; bit 0 is always 0
module operand_hazard_unit_reg_scoreboard
  import operand_hazard_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_rd,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
    // Clear first, then set: the issuing instruction is younger than the writeback.
    busy_d = (busy_q & ~clr_mask) | set_mask;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_hazard_unit.sv
// Forwarding select and hazard stall generation for the RV32I pipeline.
// Ports:
//   clk, rst, flush                  clock, synchronous active-high reset, pipeline flush
//   src_rs, src_used                 source register indices (5 bits each) and read flags
//   stage_rd, stage_load_rf          producer stage destinations and regfile-write flags
//   stage_ready                      producer stage result is forwardable this cycle
//   issue_valid, issue_rd, issue_long  instruction leaving ID; long ops are scoreboarded
//   wb_valid, wb_rd                  regfile write port
//   fwd_sel                          per source: 0 = regfile, k = forward from stage k-1
//   stall                            hold IF/ID, bubble into EX
//   busy_vec                         scoreboard state
//   stall_cycles                     saturating stall counter, only with HAZARD_PERF_EN
// Optional feature macro: HAZARD_PERF_EN
module operand_hazard_unit
  import operand_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_SRC*5-1:0]         src_rs,
  input  logic [NUM_SRC-1:0]           src_used,
  input  logic [NUM_STAGES*5-1:0]      stage_rd,
  input  logic [NUM_STAGES-1:0]        stage_load_rf,
  input  logic [NUM_STAGES-1:0]        stage_ready,
  input  logic                         issue_valid,
  input  logic [4:0]                   issue_rd,
  input  logic                         issue_long,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_rd,
  output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
  output logic                         stall,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                  stall_cycles,
`endif
  output logic [31:0]                  busy_vec
);

  logic sb_set;

  // Per-source match search: scan oldest to youngest so the youngest match is the last written.
  always_comb begin
    logic             hit;
    logic             hit_ready;
    logic [SEL_W-1:0] sel;
    logic [4:0]       rs;
    logic [4:0]       rd;
    fwd_sel = '0;
    stall   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      sel       = SEL_W'(FWD_SEL_REGFILE);
      rs        = src_rs[i*5 +: 5];
      for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
        rd = stage_rd[k*5 +: 5];
        if (stage_load_rf[k] && (rd != 5'd0) && (rd == rs)) begin
          hit       = 1'b1;
          hit_ready = stage_ready[k];
          sel       = SEL_W'(fwd_sel_of_stage(unsigned'(k)));
        end
      end
      fwd_sel[i*SEL_W +: SEL_W] = sel;
      // An unmatched busy register means its long op has not reached a forwardable stage yet.
      if (src_used[i] && (hit ? !hit_ready : busy_vec[rs])) stall = 1'b1;
    end
  end

  // A stalled issue did not advance, so it must not claim its destination.
  assign sb_set = issue_valid && !stall && issue_long;

  operand_hazard_unit_reg_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .set_en (sb_set),
    .set_rd (issue_rd),
    .clr_en (wb_valid),
    .clr_rd (wb_rd),
    .busy   (busy_vec)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
